// File: rtl/vc_dest_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vc_dest_arbiter_pkg
// Brief    : State encodings and shared defaults for the VC-to-destination arbiter.
// Revision : 1.0
// ============================================================================
package vc_dest_arbiter_pkg;

   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_RESET  = 3'd0;
   localparam logic [STATE_W-1:0] ST_INIT   = 3'd1;
   localparam logic [STATE_W-1:0] ST_IDLE   = 3'd2;
   localparam logic [STATE_W-1:0] ST_ACTIVE = 3'd3;
   localparam logic [STATE_W-1:0] ST_ERROR  = 3'd4;

   localparam int DEST_BIT_DEFAULT = 4;

   // Pop-select encoding carried down the pipeline with each in-flight word.
   localparam logic SEL_VC0 = 1'b0;
   localparam logic SEL_VC1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/vc_dest_arbiter_vc_pop_select.sv
`default_nettype none
// ============================================================================
// Module   : vc_pop_select
// Brief    : Pop grant between VC0 and VC1; VC_ROUND_ROBIN_EN selects alternation.
// Revision : 1.0
// ============================================================================
module vc_pop_select
   import vc_dest_arbiter_pkg::*;
(
`ifdef VC_ROUND_ROBIN_EN
   input  logic clk,
   input  logic reset_L,
`endif
   input  logic allowed,
   input  logic vc0_empty,
   input  logic vc1_empty,
   output logic vc0_pop,
   output logic vc1_pop,
   output logic pop_sel
);

   logic pick_vc1;

`ifdef VC_ROUND_ROBIN_EN
   logic last_grant_q;
   logic last_grant_d;

   // Resetting to VC1 makes the first contested grant go to VC0.
   always_comb begin
      pick_vc1 = vc0_empty;
      if (!vc0_empty && !vc1_empty) begin
         pick_vc1 = (last_grant_q == SEL_VC0);
      end
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (vc1_pop) begin
         last_grant_d = SEL_VC1;
      end else if (vc0_pop) begin
         last_grant_d = SEL_VC0;
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         last_grant_q <= SEL_VC1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
`else
   always_comb begin
      pick_vc1 = vc0_empty;
   end
`endif

   always_comb begin
      vc0_pop = allowed & ~vc0_empty & ~pick_vc1;
      vc1_pop = allowed & ~vc1_empty &  pick_vc1;
      pop_sel = pick_vc1 ? SEL_VC1 : SEL_VC0;
   end

endmodule
`default_nettype wire

// File: rtl/vc_dest_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vc_dest_arbiter
// Brief    : Pops VC0/VC1 FIFOs and routes each word to D0/D1 by its destination
//            bit. Optional VC_ROUND_ROBIN_EN alternates VC pops when both are ready.
// Revision : 1.0
// ============================================================================
module vc_dest_arbiter
   import vc_dest_arbiter_pkg::*;
#(
   parameter int DATA_SIZE = 6,
   parameter int DEST_BIT  = DEST_BIT_DEFAULT,
   parameter int CNT_SIZE  = 8
) (
   input  logic                 clk,
   input  logic                 reset_L,
   input  logic                 init,
   input  logic                 vc0_empty,
   input  logic                 vc1_empty,
   input  logic [DATA_SIZE-1:0] vc0_data,
   input  logic [DATA_SIZE-1:0] vc1_data,
   input  logic                 d0_pause,
   input  logic                 d1_pause,
   input  logic                 d0_error,
   input  logic                 d1_error,
   output logic                 vc0_pop,
   output logic                 vc1_pop,
   output logic                 push_d0,
   output logic                 push_d1,
   output logic [DATA_SIZE-1:0] data_d0,
   output logic [DATA_SIZE-1:0] data_d1,
   output logic [CNT_SIZE-1:0]  cnt_d0,
   output logic [CNT_SIZE-1:0]  cnt_d1,
   output logic [2:0]           state,
   output logic                 idle,
   output logic                 error
);

   logic [STATE_W-1:0]   state_q,   state_d;
   logic                 s1_valid_q, s1_valid_d;
   logic                 s1_sel_q,   s1_sel_d;
   logic                 push_d0_q, push_d0_d;
   logic                 push_d1_q, push_d1_d;
   logic [DATA_SIZE-1:0] data_d0_q, data_d0_d;
   logic [DATA_SIZE-1:0] data_d1_q, data_d1_d;
   logic [CNT_SIZE-1:0]  cnt_d0_q,  cnt_d0_d;
   logic [CNT_SIZE-1:0]  cnt_d1_q,  cnt_d1_d;

   logic                 w_running;
   logic                 w_err_in;
   logic                 w_allowed;
   logic                 w_kill;
   logic                 w_pop_sel;
   logic [DATA_SIZE-1:0] w_word;
   logic                 w_dest;
   logic                 w_fwd;

   // An error sampled this cycle already suppresses the pop and flushes the pipe.
   always_comb begin
      w_running = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
      w_err_in  = w_running & (d0_error | d1_error);
      w_allowed = w_running & ~d0_pause & ~d1_pause & ~w_err_in;
      w_kill    = w_err_in | (state_q == ST_ERROR);
   end

   vc_pop_select u_pop_select (
`ifdef VC_ROUND_ROBIN_EN
      .clk       (clk),
      .reset_L   (reset_L),
`endif
      .allowed   (w_allowed),
      .vc0_empty (vc0_empty),
      .vc1_empty (vc1_empty),
      .vc0_pop   (vc0_pop),
      .vc1_pop   (vc1_pop),
      .pop_sel   (w_pop_sel)
   );

   always_comb begin
      s1_valid_d = vc0_pop | vc1_pop;
      s1_sel_d   = w_pop_sel;
      w_word     = (s1_sel_q == SEL_VC1) ? vc1_data : vc0_data;
      w_dest     = w_word[DEST_BIT];
      w_fwd      = s1_valid_q & ~w_kill;
      push_d0_d  = w_fwd & ~w_dest;
      push_d1_d  = w_fwd &  w_dest;
      data_d0_d  = push_d0_d ? w_word : data_d0_q;
      data_d1_d  = push_d1_d ? w_word : data_d1_q;
      cnt_d0_d   = cnt_d0_q + {{(CNT_SIZE-1){1'b0}}, push_d0_d};
      cnt_d1_d   = cnt_d1_q + {{(CNT_SIZE-1){1'b0}}, push_d1_d};
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RESET:  state_d = ST_INIT;
         ST_INIT:   state_d = init ? ST_INIT : ST_IDLE;
         ST_IDLE: begin
            if (w_err_in) begin
               state_d = ST_ERROR;
            end else if (!vc0_empty || !vc1_empty) begin
               state_d = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (w_err_in) begin
               state_d = ST_ERROR;
            end else if (vc0_empty && vc1_empty && !s1_valid_q && !push_d0_q && !push_d1_q) begin
               state_d = ST_IDLE;
            end
         end
         // Sticky; only a reset or a fresh init request leaves it.
         ST_ERROR:  state_d = init ? ST_INIT : ST_ERROR;
         default:   state_d = ST_RESET;
      endcase
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q    <= ST_RESET;
         s1_valid_q <= 1'b0;
         s1_sel_q   <= SEL_VC0;
         push_d0_q  <= 1'b0;
         push_d1_q  <= 1'b0;
         data_d0_q  <= '0;
         data_d1_q  <= '0;
         cnt_d0_q   <= '0;
         cnt_d1_q   <= '0;
      end else begin
         state_q    <= state_d;
         s1_valid_q <= s1_valid_d;
         s1_sel_q   <= s1_sel_d;
         push_d0_q  <= push_d0_d;
         push_d1_q  <= push_d1_d;
         data_d0_q  <= data_d0_d;
         data_d1_q  <= data_d1_d;
         cnt_d0_q   <= cnt_d0_d;
         cnt_d1_q   <= cnt_d1_d;
      end
   end

   assign push_d0 = push_d0_q;
   assign push_d1 = push_d1_q;
   assign data_d0 = data_d0_q;
   assign data_d1 = data_d1_q;
   assign cnt_d0  = cnt_d0_q;
   assign cnt_d1  = cnt_d1_q;
   assign state   = state_q;
   assign idle    = (state_q == ST_IDLE);
   assign error   = (state_q == ST_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_vc_dest_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vc_dest_arbiter
// Brief    : Scoreboard bench for vc_dest_arbiter with simple VC FIFO models.
// Revision : 1.0
// ============================================================================
module tb_vc_dest_arbiter;

   logic       clk;
   logic       reset_L;
   logic       init;
   logic       vc0_empty, vc1_empty;
   logic [5:0] vc0_data, vc1_data;
   logic       d0_pause, d1_pause, d0_error, d1_error;
   logic       vc0_pop, vc1_pop, push_d0, push_d1;
   logic [5:0] data_d0, data_d1;
   logic [7:0] cnt_d0, cnt_d1;
   logic [2:0] state;
   logic       idle, error;

   vc_dest_arbiter #(.DATA_SIZE(6), .DEST_BIT(4), .CNT_SIZE(8)) dut (
      .clk(clk), .reset_L(reset_L), .init(init),
      .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
      .vc0_data(vc0_data), .vc1_data(vc1_data),
      .d0_pause(d0_pause), .d1_pause(d1_pause),
      .d0_error(d0_error), .d1_error(d1_error),
      .vc0_pop(vc0_pop), .vc1_pop(vc1_pop),
      .push_d0(push_d0), .push_d1(push_d1),
      .data_d0(data_d0), .data_d1(data_d1),
      .cnt_d0(cnt_d0), .cnt_d1(cnt_d1),
      .state(state), .idle(idle), .error(error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // VC FIFO models: read data appears the cycle after the pop.
   logic [5:0] mem0 [0:1023];
   logic [5:0] mem1 [0:1023];
   int vc0_wr = 0, vc0_rd = 0, vc1_wr = 0, vc1_rd = 0;
   assign vc0_empty = (vc0_wr == vc0_rd);
   assign vc1_empty = (vc1_wr == vc1_rd);

   initial begin
      vc0_data = '0;
      vc1_data = '0;
   end
   always @(posedge clk) begin
      if (vc0_pop) begin
         vc0_data <= mem0[vc0_rd % 1024];
         vc0_rd   <= vc0_rd + 1;
      end
      if (vc1_pop) begin
         vc1_data <= mem1[vc1_rd % 1024];
         vc1_rd   <= vc1_rd + 1;
      end
   end

   typedef struct {
      logic       dest;
      logic [5:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   lat_q[$];
   int   checks = 0;
   int   errors = 0;
   int   n_push = 0;
   logic [7:0] exp_cnt0 = 0;
   logic [7:0] exp_cnt1 = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=event required=none (t=%0t)", name, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int vc, input logic [5:0] d);
      if (vc == 0) begin
         mem0[vc0_wr % 1024] = d;
         vc0_wr++;
      end else begin
         mem1[vc1_wr % 1024] = d;
         vc1_wr++;
      end
   endtask

   // Routing model: bit 4 of the word picks D1.
   task automatic expect_push(input logic [5:0] d);
      exp_t e;
      e.dest = d[4];
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      repeat (3) step();
      while (!(state == 3'd2 && exp_q.size() == 0) && n < budget) begin
         step();
         n++;
      end
      chk("drain_to_idle", {31'd0, (state == 3'd2 && exp_q.size() == 0)}, 32'd1);
   endtask

   task automatic chk_pops_zero(input string name);
      chk(name, {30'd0, vc0_pop, vc1_pop}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] w;
      int n_before;

      reset_L  = 1'b0;
      init     = 1'b1;
      d0_pause = 1'b0;
      d1_pause = 1'b0;
      d0_error = 1'b0;
      d1_error = 1'b0;

      fork
         forever begin
            exp_t e;
            @(negedge clk);
            if (!reset_L) begin
               exp_cnt0 = 0;
               exp_cnt1 = 0;
            end else begin
               if (vc0_pop && vc1_pop) flag("dual_pop");
               if (vc0_pop || vc1_pop) lat_q.push_back(cyc);
               if (push_d0 && push_d1) begin
                  flag("dual_push");
               end else if (push_d0 || push_d1) begin
                  n_push++;
                  if (exp_q.size() == 0) begin
                     flag("unexpected_push");
                  end else begin
                     e = exp_q.pop_front();
                     chk("push_dest", {31'd0, push_d1}, {31'd0, e.dest});
                     chk("push_data", {26'd0, (push_d1 ? data_d1 : data_d0)}, {26'd0, e.data});
                     if (push_d0) begin
                        exp_cnt0 = exp_cnt0 + 8'd1;
                        chk("cnt_d0", {24'd0, cnt_d0}, {24'd0, exp_cnt0});
                     end else begin
                        exp_cnt1 = exp_cnt1 + 8'd1;
                        chk("cnt_d1", {24'd0, cnt_d1}, {24'd0, exp_cnt1});
                     end
                  end
                  if (lat_q.size() == 0) flag("push_without_pop");
                  else chk("pop_to_push_latency", cyc - lat_q.pop_front(), 32'd2);
               end
            end
         end
      join_none

      // Reset values
      #3;
      chk("rst_state", {29'd0, state}, 32'd0);
      chk("rst_push", {30'd0, push_d0, push_d1}, 32'd0);
      chk("rst_data", {20'd0, data_d0, data_d1}, 32'd0);
      chk("rst_cnt", {16'd0, cnt_d0, cnt_d1}, 32'd0);
      chk("rst_idle_error", {30'd0, idle, error}, 32'd0);
      chk_pops_zero("rst_pops");
      step();
      step();
      reset_L = 1'b1;
      step();
      chk("init_state", {29'd0, state}, 32'd1);
      step();
      chk("init_hold", {29'd0, state}, 32'd1);
      init = 1'b0;
      step();
      chk("idle_state", {29'd0, state}, 32'd2);
      chk("idle_flag", {31'd0, idle}, 32'd1);

      // Two VC0 words, one per destination
      load(0, 6'h05); expect_push(6'h05);
      load(0, 6'h15); expect_push(6'h15);
      wait_idle(40);
      chk("t1_cnt_d0", {24'd0, cnt_d0}, 32'd1);
      chk("t1_cnt_d1", {24'd0, cnt_d1}, 32'd1);

      // Both VCs loaded with three words each
      load(0, 6'h01); load(0, 6'h12); load(0, 6'h03);
      load(1, 6'h21); load(1, 6'h32); load(1, 6'h23);
`ifdef VC_ROUND_ROBIN_EN
      // Previous grant was VC0, so VC1 wins the first contested pop.
      expect_push(6'h21); expect_push(6'h01);
      expect_push(6'h32); expect_push(6'h12);
      expect_push(6'h23); expect_push(6'h03);
`else
      expect_push(6'h01); expect_push(6'h12); expect_push(6'h03);
      expect_push(6'h21); expect_push(6'h32); expect_push(6'h23);
`endif
      #1;
      chk("t2_first_pop", {30'd0, vc0_pop, vc1_pop},
`ifdef VC_ROUND_ROBIN_EN
          32'd1
`else
          32'd2
`endif
      );
      wait_idle(40);

      // Pause during a stream
      for (int i = 0; i < 8; i++) begin
         w = 6'(i) | ((i % 2 == 1) ? 6'h10 : 6'h00);
         load(0, w);
         expect_push(w);
      end
      step();
      step();
      step();
      d1_pause = 1'b1;
      n_before = n_push;
      #1;
      chk_pops_zero("pause_pop_c0");
      for (int i = 1; i < 4; i++) begin
         step();
         chk_pops_zero("pause_pop");
      end
      step();
      chk("pause_inflight_pushes", n_push - n_before, 32'd2);
      d1_pause = 1'b0;
      #1;
      chk("pause_resume_pop", {31'd0, vc0_pop}, 32'd1);
      wait_idle(40);

      // Error while ACTIVE
      for (int i = 1; i <= 6; i++) load(0, 6'(i));
      expect_push(6'h01);
      step();
      step();
      d0_error = 1'b1;
      #1;
      chk_pops_zero("err_same_cycle_pop");
      step();
      d0_error = 1'b0;
      #1;
      chk("err_state", {29'd0, state}, 32'd4);
      chk("err_flag", {30'd0, error, idle}, 32'd2);
      for (int i = 0; i < 3; i++) begin
         chk_pops_zero("err_pops");
         chk("err_push", {30'd0, push_d0, push_d1}, 32'd0);
         step();
      end
      chk("err_sticky", {29'd0, state}, 32'd4);
      chk("err_queue_drained", exp_q.size(), 32'd0);
      vc0_wr = vc0_rd;
      lat_q.delete();
      reset_L = 1'b0;
      #1;
      chk("err_reset_state", {29'd0, state}, 32'd0);
      step();
      reset_L = 1'b1;
      step();
      step();
      chk("post_err_idle", {29'd0, state}, 32'd2);

      // 256 pushes to D0 wrap the counter
      for (int i = 0; i < 256; i++) begin
         w = 6'(i & 15);
         load(0, w);
         expect_push(w);
      end
      wait_idle(400);
      chk("wrap_cnt_d0", {24'd0, cnt_d0}, 32'd0);
      chk("wrap_cnt_d1", {24'd0, cnt_d1}, 32'd0);

      // Asynchronous reset with two words in flight
      load(0, 6'h07); load(0, 6'h18); load(0, 6'h09); load(0, 6'h1A);
      step();
      step();
      reset_L = 1'b0;
      #1;
      chk("async_state", {29'd0, state}, 32'd0);
      chk("async_push", {30'd0, push_d0, push_d1}, 32'd0);
      chk("async_data", {20'd0, data_d0, data_d1}, 32'd0);
      chk("async_cnt", {16'd0, cnt_d0, cnt_d1}, 32'd0);
      chk("async_flags", {30'd0, idle, error}, 32'd0);
      chk_pops_zero("async_pops");
      vc0_wr = vc0_rd;
      lat_q.delete();
      step();
      step();
      reset_L = 1'b1;
      n_before = n_push;
      repeat (6) step();
      chk("post_async_no_push", n_push - n_before, 32'd0);
      chk("post_async_state", {29'd0, state}, 32'd2);
      chk("post_async_cnt", {16'd0, cnt_d0, cnt_d1}, 32'd0);
      chk("final_queue_empty", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
